// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundle of the writeback requester handshakes, the issue-stage hazard query
// and the registered register-file write port served by regfile_wb_arbiter.
//
//   alu_valid/alu_ready/alu_rd/alu_data  ALU writeback request
//   mem_valid/mem_ready/mem_rd/mem_data  load writeback request
//   issue_valid/issue_has_rd/issue_rd/issue_rs1/issue_rs2/issue_stall
//                                        issue-stage scoreboard query
//   regwrite/write_reg/write_data        register-file write port
//
// Modports:
//   master - requesters, issue stage and register file (drive requests/query)
//   slave  - the arbiter (grants, stalls, drives the write port)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_data;

   logic              issue_valid;
   logic              issue_has_rd;
   logic [ADDR_W-1:0] issue_rd;
   logic [ADDR_W-1:0] issue_rs1;
   logic [ADDR_W-1:0] issue_rs2;
   logic              issue_stall;

   logic              regwrite;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] write_data;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      output issue_valid, issue_has_rd, issue_rd, issue_rs1, issue_rs2,
      input  alu_ready, mem_ready, issue_stall,
      input  regwrite, write_reg, write_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      input  issue_valid, issue_has_rd, issue_rd, issue_rs1, issue_rs2,
      output alu_ready, mem_ready, issue_stall,
      output regwrite, write_reg, write_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Round-robin arbiter for the single write port of the register file, shared
// by the ALU and load writeback paths, plus a per-register busy scoreboard the
// issue stage uses to stall on RAW/WAW hazards.
//
// Ports:
//   clock           single clock, posedge
//   reset           synchronous, active-high
//   bus             regfile_wb_arbiter_if.slave (requests, issue query,
//                   registered regwrite/write_reg/write_data)
//   conflict_count  saturating count of cycles with both requesters valid;
//                   present only when CONFLICT_CNT_EN is defined
//
// Optional build macro: CONFLICT_CNT_EN
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   regfile_wb_arbiter_if.slave     bus
`ifdef CONFLICT_CNT_EN
   ,
   output logic [CNT_W-1:0]        conflict_count
`endif
);

   localparam int NREG = 2 ** ADDR_W;

   // Whose turn it is when both requesters collide.
   typedef enum logic {
      PTR_ALU = 1'b0,
      PTR_MEM = 1'b1
   } ptr_t;

   ptr_t              ptr_r;
   ptr_t              ptr_next_s;
   logic              alu_grant_s;
   logic              mem_grant_s;
   logic              both_valid_s;

   logic              regwrite_r;
   logic [ADDR_W-1:0] write_reg_r;
   logic [DATA_W-1:0] write_data_r;

   logic [NREG-1:0]   busy_r;
   logic [NREG-1:0]   busy_next_s;
   logic              stall_s;
   logic              issue_fire_s;

   assign both_valid_s = bus.alu_valid & bus.mem_valid;

   // Round-robin pointer register.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_r <= PTR_ALU;
      end else begin
         ptr_r <= ptr_next_s;
      end
   end

   // Grant decode and pointer next state; the loser of a collision gets the next one.
   always_comb begin
      alu_grant_s = 1'b0;
      mem_grant_s = 1'b0;
      ptr_next_s  = ptr_r;
      if (reset) begin
         alu_grant_s = 1'b0;
         mem_grant_s = 1'b0;
      end else if (both_valid_s) begin
         case (ptr_r)
            PTR_ALU: begin
               alu_grant_s = 1'b1;
               ptr_next_s  = PTR_MEM;
            end
            PTR_MEM: begin
               mem_grant_s = 1'b1;
               ptr_next_s  = PTR_ALU;
            end
            default: begin
               alu_grant_s = 1'b1;
               ptr_next_s  = PTR_MEM;
            end
         endcase
      end else if (bus.alu_valid) begin
         alu_grant_s = 1'b1;
      end else if (bus.mem_valid) begin
         mem_grant_s = 1'b1;
      end else begin
         alu_grant_s = 1'b0;
         mem_grant_s = 1'b0;
      end
   end

   assign bus.alu_ready = alu_grant_s;
   assign bus.mem_ready = mem_grant_s;

   // Write stage: capture the granted request; x0 completes the handshake without writing.
   always_ff @(posedge clock) begin
      if (reset) begin
         regwrite_r   <= 1'b0;
         write_reg_r  <= {ADDR_W{1'b0}};
         write_data_r <= {DATA_W{1'b0}};
      end else if (alu_grant_s) begin
         regwrite_r   <= (bus.alu_rd != {ADDR_W{1'b0}});
         write_reg_r  <= bus.alu_rd;
         write_data_r <= bus.alu_data;
      end else if (mem_grant_s) begin
         regwrite_r   <= (bus.mem_rd != {ADDR_W{1'b0}});
         write_reg_r  <= bus.mem_rd;
         write_data_r <= bus.mem_data;
      end else begin
         regwrite_r   <= 1'b0;
      end
   end

   assign bus.regwrite   = regwrite_r;
   assign bus.write_reg  = write_reg_r;
   assign bus.write_data = write_data_r;

   // Hazard detect; no bypass, so a write landing at the coming edge still stalls.
   always_comb begin
      stall_s = 1'b0;
      if (reset) begin
         stall_s = 1'b1;
      end else if (bus.issue_valid) begin
         stall_s = ((bus.issue_rs1 != {ADDR_W{1'b0}}) && busy_r[bus.issue_rs1]) ||
                   ((bus.issue_rs2 != {ADDR_W{1'b0}}) && busy_r[bus.issue_rs2]) ||
                   (bus.issue_has_rd && (bus.issue_rd != {ADDR_W{1'b0}}) &&
                    busy_r[bus.issue_rd]);
      end else begin
         stall_s = 1'b0;
      end
   end

   assign bus.issue_stall = stall_s;
   assign issue_fire_s    = bus.issue_valid & ~stall_s & bus.issue_has_rd &
                            (bus.issue_rd != {ADDR_W{1'b0}});

   // Scoreboard next state: clear the landing write first so a new producer's set wins.
   always_comb begin
      busy_next_s = busy_r;
      if (regwrite_r) begin
         busy_next_s[write_reg_r] = 1'b0;
      end else begin
         busy_next_s = busy_r;
      end
      if (issue_fire_s) begin
         busy_next_s[bus.issue_rd] = 1'b1;
      end else begin
         busy_next_s[0] = 1'b0;
      end
      busy_next_s[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_r <= {NREG{1'b0}};
      end else begin
         busy_r <= busy_next_s;
      end
   end

`ifdef CONFLICT_CNT_EN
   logic [CNT_W-1:0] conflict_cnt_r;

   // Saturating count of collision cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         conflict_cnt_r <= {CNT_W{1'b0}};
      end else if (both_valid_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
         conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign conflict_count = conflict_cnt_r;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. A behavioural model (busy set,
// expected pending write, collision turn, register file contents) is advanced
// on every posedge from the inputs alone; a negedge compare process checks
// all DUT outputs against it, and the stimulus block pins the model with
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef CONFLICT_CNT_EN
   logic [15:0] conflict_count;
`endif

   regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus.slave)
`ifdef CONFLICT_CNT_EN
      ,
      .conflict_count (conflict_count)
`endif
   );

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   // Behavioural model state.
   bit          m_busy [32];
   logic [31:0] m_rf   [32];
   bit          m_regwrite = 1'b0;
   logic [4:0]  m_wreg = 5'd0;
   logic [31:0] m_wdata = 32'd0;
   bit          m_turn_mem = 1'b0;
   int          m_cnt = 0;
   bit          a_g, m_g, st;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_stall();
      if (reset) return 1'b1;
      if (!bus.issue_valid) return 1'b0;
      return (bus.issue_rs1 != 5'd0 && m_busy[bus.issue_rs1]) ||
             (bus.issue_rs2 != 5'd0 && m_busy[bus.issue_rs2]) ||
             (bus.issue_has_rd && bus.issue_rd != 5'd0 && m_busy[bus.issue_rd]);
   endfunction

   function automatic bit model_alu_grant();
      return !reset && bus.alu_valid && (!bus.mem_valid || !m_turn_mem);
   endfunction

   function automatic bit model_mem_grant();
      return !reset && bus.mem_valid && (!bus.alu_valid || m_turn_mem);
   endfunction

   // Model advance on each clock edge.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         m_regwrite = 1'b0;
         m_wreg     = 5'd0;
         m_wdata    = 32'd0;
         m_turn_mem = 1'b0;
         m_cnt      = 0;
      end else begin
         a_g = model_alu_grant();
         m_g = model_mem_grant();
         st  = model_stall();
         if (m_regwrite) begin
            m_rf[m_wreg]   = m_wdata;
            m_busy[m_wreg] = 1'b0;
         end
         if (bus.issue_valid && !st && bus.issue_has_rd && bus.issue_rd != 5'd0)
            m_busy[bus.issue_rd] = 1'b1;
         if (a_g) begin
            m_regwrite = (bus.alu_rd != 5'd0);
            m_wreg     = bus.alu_rd;
            m_wdata    = bus.alu_data;
         end else if (m_g) begin
            m_regwrite = (bus.mem_rd != 5'd0);
            m_wreg     = bus.mem_rd;
            m_wdata    = bus.mem_data;
         end else begin
            m_regwrite = 1'b0;
         end
         if (bus.alu_valid && bus.mem_valid) begin
            m_turn_mem = a_g;
            if (m_cnt < 65535) m_cnt++;
         end
      end
   end

   // Compare process: every output against the model, away from the active edge.
   always @(negedge clock) begin
      if (started) begin
         check("alu_ready",   64'(bus.alu_ready),   64'(model_alu_grant()));
         check("mem_ready",   64'(bus.mem_ready),   64'(model_mem_grant()));
         check("issue_stall", 64'(bus.issue_stall), 64'(model_stall()));
         check("regwrite",    64'(bus.regwrite),    64'(m_regwrite));
         check("write_reg",   64'(bus.write_reg),   64'(m_wreg));
         check("write_data",  64'(bus.write_data),  64'(m_wdata));
`ifdef CONFLICT_CNT_EN
         check("conflict_count", 64'(conflict_count), 64'(m_cnt));
`endif
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
      bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
      bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0;
      bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

      // Reset state, with a request present that must not be accepted.
      tick(); tick();
      started = 1'b1;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
      #1;
      check("rst_alu_ready", 64'(bus.alu_ready), 64'h0);
      check("rst_stall",     64'(bus.issue_stall), 64'h1);
      check("rst_regwrite",  64'(bus.regwrite), 64'h0);
      check("rst_write_reg", 64'(bus.write_reg), 64'h0);
      tick();

      // Single ALU write to x5.
      reset = 1'b0;
      #1;
      check("t1_ready", 64'(bus.alu_ready), 64'h1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      check("t1_regwrite", 64'(bus.regwrite),   64'h1);
      check("t1_wreg",     64'(bus.write_reg),  64'h5);
      check("t1_wdata",    64'(bus.write_data), 64'hDEADBEEF);
      tick();
      #1;
      check("t1_regwrite_off", 64'(bus.regwrite), 64'h0);

      // Both requesters held for 4 cycles: ALU, MEM, ALU, MEM.
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA0A00003;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hB0B00004;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_alu_ready", 64'(bus.alu_ready), (i % 2 == 0) ? 64'h1 : 64'h0);
         check("t2_mem_ready", 64'(bus.mem_ready), (i % 2 == 1) ? 64'h1 : 64'h0);
         tick();
         #1;
         check("t2_regwrite", 64'(bus.regwrite),  64'h1);
         check("t2_wreg",     64'(bus.write_reg), (i % 2 == 0) ? 64'h3 : 64'h4);
      end
`ifdef CONFLICT_CNT_EN
      check("t2_conflicts", 64'(conflict_count), 64'h4);
`endif
      bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
      tick();

      // RAW on x7: stall until the cycle after the regwrite to 7.
      bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd7;
      #1;
      check("t3_issue_rd7", 64'(bus.issue_stall), 64'h0);
      tick();
      bus.issue_has_rd = 1'b0; bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd7;
      #1;
      check("t3_stall_a", 64'(bus.issue_stall), 64'h1);
      tick();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h00000077;
      #1;
      check("t3_stall_b", 64'(bus.issue_stall), 64'h1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      check("t3_regwrite7",  64'(bus.write_reg),   64'h7);
      check("t3_stall_land", 64'(bus.issue_stall), 64'h1);
      tick();
      #1;
      check("t3_released", 64'(bus.issue_stall), 64'h0);
      check("t3_rf7",      64'(m_rf[7]),         64'h77);
      bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd0;
      tick();

      // Write to x0 and an issue touching only x0.
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00001234;
      bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd0;
      #1;
      check("t4_ready", 64'(bus.alu_ready),   64'h1);
      check("t4_stall", 64'(bus.issue_stall), 64'h0);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      check("t4_regwrite", 64'(bus.regwrite),   64'h0);
      check("t4_stall2",   64'(bus.issue_stall), 64'h0);
      bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0;
      tick();

      // Same-edge set/clear on x9: set wins.
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h00000091;
      tick();
      bus.alu_valid = 1'b0;
      bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd9;
      #1;
      check("t5_regwrite9", 64'(bus.write_reg),   64'h9);
      check("t5_no_stall",  64'(bus.issue_stall), 64'h0);
      tick();
      bus.issue_has_rd = 1'b0; bus.issue_rd = 5'd0; bus.issue_rs2 = 5'd9;
      #1;
      check("t5_stall_rs2", 64'(bus.issue_stall), 64'h1);
      tick();
      bus.alu_valid = 1'b1; bus.alu_data = 32'h00000092;
      tick();
      bus.alu_valid = 1'b0;
      #1;
      check("t5_stall_land", 64'(bus.issue_stall), 64'h1);
      tick();
      #1;
      check("t5_released", 64'(bus.issue_stall), 64'h0);
      check("t5_rf9",      64'(m_rf[9]),         64'h92);
      bus.issue_valid = 1'b0; bus.issue_rs2 = 5'd0;
      tick();

      // Reset while a load to busy x12 is in flight.
      bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd12;
      tick();
      bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0; bus.issue_rd = 5'd0;
      bus.mem_valid = 1'b1; bus.mem_rd = 5'd12; bus.mem_data = 32'h0000C0DE;
      tick();
      bus.mem_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("t6_inflight", 64'(bus.regwrite), 64'h1);
      tick();
      #1;
      check("t6_dropped", 64'(bus.regwrite), 64'h0);
      reset = 1'b0;
      bus.issue_valid = 1'b1; bus.issue_rs1 = 5'd12;
      #1;
      check("t6_no_stall", 64'(bus.issue_stall), 64'h0);
      tick();
      bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
